// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control unit.
package mc_ctrl_pkg;

   // FSM state encoding; 4'hF is unused and recovers to FETCH
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEMADR    = 4'd2,
      S_MEMREAD   = 4'd3,
      S_MEMWB     = 4'd4,
      S_MEMWRITE  = 4'd5,
      S_EXECR     = 4'd6,
      S_EXECI     = 4'd7,
      S_ALUWB     = 4'd8,
      S_JAL       = 4'd9,
      S_JALR      = 4'd10,
      S_JALR_LINK = 4'd11,
      S_BRANCH    = 4'd12,
      S_UPPER     = 4'd13,
      S_TRAP      = 4'd14
   } state_e;

   // ALU operation class handed from the FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   // alu_control codes
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   // immediate formats
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // datapath mux selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   // major opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // branch condition from funct3 and the SUB flags; 010/011 never taken
   function automatic logic branch_take(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
      case (f3)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b100:  return lt;
         3'b101:  return !lt;
         3'b110:  return ltu;
         3'b111:  return !ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: maps the FSM's aluop class plus funct fields to alu_control.
module alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [1:0] i_aluop,
   input  logic [2:0] i_f3,
   input  logic       i_op5,
   input  logic       i_f7,
   output logic [3:0] o_alu_control
);

   // op[5] separates R-type from I-type so immediates with bit30 set never SUB
   always_comb begin
      o_alu_control = ALU_ADD;
      case (i_aluop)
         ALUOP_SUB: o_alu_control = ALU_SUB;
         ALUOP_FUNC: begin
            case (i_f3)
               3'b000:  o_alu_control = (i_op5 && i_f7) ? ALU_SUB : ALU_ADD;
               3'b001:  o_alu_control = ALU_SLL;
               3'b010:  o_alu_control = ALU_SLT;
               3'b011:  o_alu_control = ALU_SLTU;
               3'b100:  o_alu_control = ALU_XOR;
               3'b101:  o_alu_control = i_f7 ? ALU_SRA : ALU_SRL;
               3'b110:  o_alu_control = ALU_OR;
               default: o_alu_control = ALU_AND;
            endcase
         end
         default: o_alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: Moore sequencer over a shared-memory,
// single-ALU datapath, with branch compare, jalr, lui/auipc, memory wait
// states, illegal-opcode trap and a retired-instruction counter.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1,
   parameter int SUPPORT_JALR  = 1,
   parameter int SUPPORT_UPPER = 1,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       i_cmd_op,
   input  logic [2:0]       i_cmd_f3,
   input  logic             i_cmd_f7,
   input  logic             i_alu_zero,
   input  logic             i_alu_lt,
   input  logic             i_alu_ltu,
   input  logic             i_mem_ready,
   output logic             o_mem_req,
   output logic             o_mem_write,
   output logic             o_ir_write,
   output logic             o_pc_write,
   output logic             o_adr_src,
   output logic             o_reg_write,
   output logic [2:0]       o_imm_src,
   output logic [1:0]       o_alu_src_a,
   output logic [1:0]       o_alu_src_b,
   output logic [1:0]       o_result_src,
   output logic [3:0]       o_alu_control,
   output logic             o_retire,
   output logic [CNT_W-1:0] o_instret,
   output logic             o_trap,
   output logic [3:0]       o_state_out
);

   state_e           r_state;
   state_e           w_next;
   logic [CNT_W-1:0] r_instret;

   logic       w_ready;
   logic       w_mem_req, w_mem_write, w_ir_write, w_adr_src, w_reg_write;
   logic       w_pc_update, w_branch, w_retire, w_trap;
   logic [1:0] w_src_a, w_src_b, w_res_src, w_aluop;
   logic [2:0] w_imm_src;
   logic [3:0] w_alu_control;

   // with handshaking disabled every memory access completes in one cycle
   assign w_ready = (MEM_HANDSHAKE != 0) ? i_mem_ready : 1'b1;

   // state register; reset overrides any pending memory wait
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (w_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (i_cmd_op)
               OP_LOAD, OP_STORE: w_next = S_MEMADR;
               OP_R:              w_next = S_EXECR;
               OP_I:              w_next = S_EXECI;
               OP_BRANCH:         w_next = S_BRANCH;
               OP_JAL:            w_next = S_JAL;
               OP_JALR:           w_next = (SUPPORT_JALR != 0) ? S_JALR : S_TRAP;
               OP_LUI, OP_AUIPC:  w_next = (SUPPORT_UPPER != 0) ? S_UPPER : S_TRAP;
               default:           w_next = S_TRAP;
            endcase
         end
         S_MEMADR:    w_next = (i_cmd_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:   if (w_ready) w_next = S_MEMWB;
         S_MEMWB:     w_next = S_FETCH;
         S_MEMWRITE:  if (w_ready) w_next = S_FETCH;
         S_EXECR,
         S_EXECI:     w_next = S_ALUWB;
         S_ALUWB:     w_next = S_FETCH;
         S_JAL:       w_next = S_ALUWB;
         S_JALR:      w_next = S_JALR_LINK;
         S_JALR_LINK: w_next = S_FETCH;
         S_BRANCH:    w_next = S_FETCH;
         S_UPPER:     w_next = S_ALUWB;
         S_TRAP:      w_next = S_TRAP;
         default:     w_next = S_FETCH;
      endcase
   end

   // per-state control outputs; memory-wait cycles keep the request up but write nothing
   always_comb begin
      w_mem_req   = 1'b0;
      w_mem_write = 1'b0;
      w_ir_write  = 1'b0;
      w_adr_src   = 1'b0;
      w_reg_write = 1'b0;
      w_pc_update = 1'b0;
      w_branch    = 1'b0;
      w_retire    = 1'b0;
      w_trap      = 1'b0;
      w_src_a     = SRCA_PC;
      w_src_b     = SRCB_RS2;
      w_res_src   = RES_ALUOUT;
      w_aluop     = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (w_ready) begin
               w_ir_write  = 1'b1;
               w_src_b     = SRCB_FOUR;
               w_res_src   = RES_ALURES;
               w_pc_update = 1'b1;
            end
         end
         S_DECODE: begin
            w_src_a = SRCA_OLDPC;
            w_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            w_src_a = SRCA_RS1;
            w_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            w_mem_req = 1'b1;
            w_adr_src = 1'b1;
         end
         S_MEMWB: begin
            w_res_src   = RES_DATA;
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
         end
         S_MEMWRITE: begin
            w_mem_req   = 1'b1;
            w_adr_src   = 1'b1;
            w_mem_write = 1'b1;
            w_retire    = w_ready;
         end
         S_EXECR: begin
            w_src_a = SRCA_RS1;
            w_aluop = ALUOP_FUNC;
         end
         S_EXECI: begin
            w_src_a = SRCA_RS1;
            w_src_b = SRCB_IMM;
            w_aluop = ALUOP_FUNC;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
         end
         S_JAL: begin
            w_src_a     = SRCA_OLDPC;
            w_src_b     = SRCB_FOUR;
            w_pc_update = 1'b1;
         end
         S_JALR: begin
            w_src_a     = SRCA_RS1;
            w_src_b     = SRCB_IMM;
            w_res_src   = RES_ALURES;
            w_pc_update = 1'b1;
         end
         S_JALR_LINK: begin
            w_src_a     = SRCA_OLDPC;
            w_src_b     = SRCB_FOUR;
            w_res_src   = RES_ALURES;
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
         end
         S_BRANCH: begin
            w_src_a  = SRCA_RS1;
            w_aluop  = ALUOP_SUB;
            w_branch = 1'b1;
            w_retire = 1'b1;
         end
         S_UPPER: begin
            w_src_a = (i_cmd_op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            w_src_b = SRCB_IMM;
         end
         S_TRAP:  w_trap = 1'b1;
         default: ;
      endcase
   end

   // immediate format follows the opcode directly, independent of state
   always_comb begin
      w_imm_src = IMM_I;
      case (i_cmd_op)
         OP_STORE:         w_imm_src = IMM_S;
         OP_BRANCH:        w_imm_src = IMM_B;
         OP_JAL:           w_imm_src = IMM_J;
         OP_LUI, OP_AUIPC: w_imm_src = IMM_U;
         default:          w_imm_src = IMM_I;
      endcase
   end

   alu_decoder u_alu_dec (
      .i_aluop       (w_aluop),
      .i_f3          (i_cmd_f3),
      .i_op5         (i_cmd_op[5]),
      .i_f7          (i_cmd_f7),
      .o_alu_control (w_alu_control)
   );

   // retired-instruction counter, wraps naturally at CNT_W bits
   always_ff @(posedge clk) begin
      if (rst)           r_instret <= '0;
      else if (w_retire) r_instret <= r_instret + CNT_W'(1);
   end

   assign o_mem_req     = w_mem_req;
   assign o_mem_write   = w_mem_write;
   assign o_ir_write    = w_ir_write;
   assign o_pc_write    = w_pc_update |
                          (w_branch & branch_take(i_cmd_f3, i_alu_zero, i_alu_lt, i_alu_ltu));
   assign o_adr_src     = w_adr_src;
   assign o_reg_write   = w_reg_write;
   assign o_imm_src     = w_imm_src;
   assign o_alu_src_a   = w_src_a;
   assign o_alu_src_b   = w_src_b;
   assign o_result_src  = w_res_src;
   assign o_alu_control = w_alu_control;
   assign o_retire      = w_retire;
   assign o_instret     = r_instret;
   assign o_trap        = w_trap;
   assign o_state_out   = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench: stimulus pushes the expected per-cycle output
// vector into a queue; a negedge monitor pops and compares.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] i_cmd_op;
   logic [2:0] i_cmd_f3;
   logic       i_cmd_f7, i_alu_zero, i_alu_lt, i_alu_ltu, i_mem_ready;
   logic       o_mem_req, o_mem_write, o_ir_write, o_pc_write, o_adr_src, o_reg_write;
   logic [2:0] o_imm_src;
   logic [1:0] o_alu_src_a, o_alu_src_b, o_result_src;
   logic [3:0] o_alu_control;
   logic       o_retire;
   logic [3:0] o_instret;
   logic       o_trap;
   logic [3:0] o_state_out;

   always #5 clk = ~clk;

   mc_control_fsm #(.MEM_HANDSHAKE(1), .SUPPORT_JALR(1), .SUPPORT_UPPER(0), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .i_cmd_op(i_cmd_op), .i_cmd_f3(i_cmd_f3), .i_cmd_f7(i_cmd_f7),
      .i_alu_zero(i_alu_zero), .i_alu_lt(i_alu_lt), .i_alu_ltu(i_alu_ltu),
      .i_mem_ready(i_mem_ready), .o_mem_req(o_mem_req), .o_mem_write(o_mem_write),
      .o_ir_write(o_ir_write), .o_pc_write(o_pc_write), .o_adr_src(o_adr_src),
      .o_reg_write(o_reg_write), .o_imm_src(o_imm_src), .o_alu_src_a(o_alu_src_a),
      .o_alu_src_b(o_alu_src_b), .o_result_src(o_result_src), .o_alu_control(o_alu_control),
      .o_retire(o_retire), .o_instret(o_instret), .o_trap(o_trap), .o_state_out(o_state_out)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       mreq, mwr, irw, pcw, adr, rw;
      logic [2:0] imm;
      logic [1:0] a, b, rs;
      logic [3:0] alu;
      logic       ret;
      logic [3:0] cnt;
      logic       trap;
   } vec_t;

   vec_t       q[$];
   string      qn[$];
   logic [3:0] icnt;
   logic [2:0] cur_imm;
   int         n_tests = 0;
   int         n_fail  = 0;

   function automatic vec_t v(input logic [3:0] st);
      vec_t e = '0;
      e.st = st; e.imm = cur_imm; e.cnt = icnt;
      return e;
   endfunction
   function automatic vec_t v_fetch(input logic rdy);
      vec_t e = v(4'd0);
      e.mreq = 1'b1;
      if (rdy) begin e.irw = 1'b1; e.pcw = 1'b1; e.b = 2'b10; e.rs = 2'b10; end
      return e;
   endfunction
   function automatic vec_t v_decode();
      vec_t e = v(4'd1); e.a = 2'b01; e.b = 2'b01; return e;
   endfunction
   function automatic vec_t v_memadr();
      vec_t e = v(4'd2); e.a = 2'b10; e.b = 2'b01; return e;
   endfunction
   function automatic vec_t v_memrd();
      vec_t e = v(4'd3); e.mreq = 1'b1; e.adr = 1'b1; return e;
   endfunction
   function automatic vec_t v_memwb();
      vec_t e = v(4'd4); e.rs = 2'b01; e.rw = 1'b1; e.ret = 1'b1; return e;
   endfunction
   function automatic vec_t v_memwr(input logic rdy);
      vec_t e = v(4'd5); e.mreq = 1'b1; e.mwr = 1'b1; e.adr = 1'b1; e.ret = rdy; return e;
   endfunction
   function automatic vec_t v_exec(input logic rtype, input logic [3:0] alu);
      vec_t e = v(rtype ? 4'd6 : 4'd7);
      e.a = 2'b10; e.b = rtype ? 2'b00 : 2'b01; e.alu = alu;
      return e;
   endfunction
   function automatic vec_t v_aluwb();
      vec_t e = v(4'd8); e.rw = 1'b1; e.ret = 1'b1; return e;
   endfunction
   function automatic vec_t v_jal();
      vec_t e = v(4'd9); e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; return e;
   endfunction
   function automatic vec_t v_jalr();
      vec_t e = v(4'd10); e.a = 2'b10; e.b = 2'b01; e.rs = 2'b10; e.pcw = 1'b1; return e;
   endfunction
   function automatic vec_t v_jlink();
      vec_t e = v(4'd11);
      e.a = 2'b01; e.b = 2'b10; e.rs = 2'b10; e.rw = 1'b1; e.ret = 1'b1;
      return e;
   endfunction
   function automatic vec_t v_branch(input logic take);
      vec_t e = v(4'd12); e.a = 2'b10; e.alu = 4'b0001; e.pcw = take; e.ret = 1'b1; return e;
   endfunction
   function automatic vec_t v_trap();
      vec_t e = v(4'd14); e.trap = 1'b1; return e;
   endfunction

   // one clock of stimulus: queue the expectation, then advance the bench's counter model
   task automatic cyc(input string nm, input vec_t e, input logic rdy, input logic r);
      i_mem_ready = rdy; rst = r;
      q.push_back(e); qn.push_back(nm);
      if (r) icnt = 4'd0;
      else if (e.ret) icnt = icnt + 4'd1;
      @(posedge clk); #1;
   endtask

   task automatic run_alu(input string nm, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [3:0] alu);
      i_cmd_op = op; i_cmd_f3 = f3; i_cmd_f7 = f7; cur_imm = 3'b000;
      cyc({nm, "/fetch"},  v_fetch(1'b1), 1'b1, 1'b0);
      cyc({nm, "/decode"}, v_decode(), 1'b1, 1'b0);
      cyc({nm, "/exec"},   v_exec(op == 7'b0110011, alu), 1'b1, 1'b0);
      cyc({nm, "/wb"},     v_aluwb(), 1'b1, 1'b0);
   endtask

   task automatic run_br(input string nm, input logic [2:0] f3, input logic z,
                         input logic lt, input logic ltu, input logic take);
      i_cmd_op = 7'b1100011; i_cmd_f3 = f3; i_cmd_f7 = 1'b0; cur_imm = 3'b010;
      i_alu_zero = z; i_alu_lt = lt; i_alu_ltu = ltu;
      cyc({nm, "/fetch"},  v_fetch(1'b1), 1'b1, 1'b0);
      cyc({nm, "/decode"}, v_decode(), 1'b1, 1'b0);
      cyc({nm, "/branch"}, v_branch(take), 1'b1, 1'b0);
   endtask

   // monitor: every cycle with a pending expectation is compared mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin : mon
         vec_t  e, act;
         string nm;
         e  = q.pop_front();
         nm = qn.pop_front();
         act = {o_state_out, o_mem_req, o_mem_write, o_ir_write, o_pc_write, o_adr_src,
                o_reg_write, o_imm_src, o_alu_src_a, o_alu_src_b, o_result_src,
                o_alu_control, o_retire, o_instret, o_trap};
         n_tests++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (state %0d vs %0d)", nm, act, e,
                     act.st, e.st);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; i_mem_ready = 1'b0; i_cmd_op = 7'd0; i_cmd_f3 = 3'd0; i_cmd_f7 = 1'b0;
      i_alu_zero = 1'b0; i_alu_lt = 1'b0; i_alu_ltu = 1'b0;
      icnt = 4'd0; cur_imm = 3'b000;
      @(posedge clk); @(posedge clk); #1;
      cyc("reset", v_fetch(1'b0), 1'b0, 1'b1);

      // fetch stall then addi x1,x0,5
      i_cmd_op = 7'b0010011; i_cmd_f3 = 3'b000;
      cyc("fetch_wait", v_fetch(1'b0), 1'b0, 1'b0);
      run_alu("addi", 7'b0010011, 3'b000, 1'b0, 4'b0000);

      // lw with three wait cycles in MEMREAD
      i_cmd_op = 7'b0000011; i_cmd_f3 = 3'b010; cur_imm = 3'b000;
      cyc("lw/fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("lw/decode", v_decode(), 1'b1, 1'b0);
      cyc("lw/memadr", v_memadr(), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc("lw/memrd_wait", v_memrd(), 1'b0, 1'b0);
      cyc("lw/memrd",  v_memrd(), 1'b1, 1'b0);
      cyc("lw/memwb",  v_memwb(), 1'b1, 1'b0);

      run_alu("sub",   7'b0110011, 3'b000, 1'b1, 4'b0001);
      run_alu("sra",   7'b0110011, 3'b101, 1'b1, 4'b1001);
      run_alu("slt",   7'b0110011, 3'b010, 1'b0, 4'b0101);
      run_alu("sll",   7'b0110011, 3'b001, 1'b0, 4'b0111);
      run_alu("srai",  7'b0010011, 3'b101, 1'b1, 4'b1001);
      run_alu("srli",  7'b0010011, 3'b101, 1'b0, 4'b1000);
      run_alu("addi_f7", 7'b0010011, 3'b000, 1'b1, 4'b0000);
      run_alu("andi",  7'b0010011, 3'b111, 1'b0, 4'b0010);
      run_alu("xori",  7'b0010011, 3'b100, 1'b0, 4'b0100);
      run_alu("sltiu", 7'b0010011, 3'b011, 1'b0, 4'b0110);
      run_alu("ori",   7'b0010011, 3'b110, 1'b0, 4'b0011);

      // sw with one wait cycle
      i_cmd_op = 7'b0100011; i_cmd_f3 = 3'b010; cur_imm = 3'b001;
      cyc("sw/fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("sw/decode", v_decode(), 1'b1, 1'b0);
      cyc("sw/memadr", v_memadr(), 1'b1, 1'b0);
      cyc("sw/wait",   v_memwr(1'b0), 1'b0, 1'b0);
      cyc("sw/write",  v_memwr(1'b1), 1'b1, 1'b0);

      run_br("bne_nz",  3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
      run_br("bne_z",   3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
      run_br("beq_z",   3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
      run_br("bltu",    3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
      run_br("blt_no",  3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
      run_br("bge",     3'b101, 1'b0, 1'b0, 1'b0, 1'b1);
      run_br("bgeu_no", 3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
      run_br("f3_010",  3'b010, 1'b1, 1'b1, 1'b1, 1'b0);

      // jal
      i_cmd_op = 7'b1101111; i_cmd_f3 = 3'b000; cur_imm = 3'b011;
      cyc("jal/fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("jal/decode", v_decode(), 1'b1, 1'b0);
      cyc("jal/jal",    v_jal(), 1'b1, 1'b0);
      cyc("jal/wb",     v_aluwb(), 1'b1, 1'b0);

      // jalr
      i_cmd_op = 7'b1100111; cur_imm = 3'b000;
      cyc("jalr/fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("jalr/decode", v_decode(), 1'b1, 1'b0);
      cyc("jalr/jalr",   v_jalr(), 1'b1, 1'b0);
      cyc("jalr/link",   v_jlink(), 1'b1, 1'b0);

      // lui with upper support disabled traps; trap is sticky until reset
      i_cmd_op = 7'b0110111; cur_imm = 3'b100;
      cyc("lui/fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("lui/decode", v_decode(), 1'b1, 1'b0);
      cyc("lui/trap0",  v_trap(), 1'b1, 1'b0);
      cyc("lui/trap1",  v_trap(), 1'b0, 1'b0);
      cyc("lui/trap_rst", v_trap(), 1'b1, 1'b1);
      cyc("lui/after_rst", v_fetch(1'b0), 1'b0, 1'b0);

      // system opcode traps
      i_cmd_op = 7'b1110011; cur_imm = 3'b000;
      cyc("ecall/fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("ecall/decode", v_decode(), 1'b1, 1'b0);
      cyc("ecall/trap0",  v_trap(), 1'b1, 1'b0);
      cyc("ecall/trap1",  v_trap(), 1'b1, 1'b0);
      cyc("ecall/trap_rst", v_trap(), 1'b0, 1'b1);

      // 16 retires wrap the 4-bit counter back to zero
      for (int i = 0; i < 16; i++) run_br("wrap_beq", 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("wrap/zero", v_fetch(1'b0), 1'b0, 1'b0);

      // reset during a store wait drops mem_write on the next cycle
      i_cmd_op = 7'b0100011; i_cmd_f3 = 3'b010; cur_imm = 3'b001;
      cyc("swrst/fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("swrst/decode", v_decode(), 1'b1, 1'b0);
      cyc("swrst/memadr", v_memadr(), 1'b1, 1'b0);
      cyc("swrst/wait",   v_memwr(1'b0), 1'b0, 1'b0);
      cyc("swrst/rst",    v_memwr(1'b0), 1'b0, 1'b1);
      cyc("swrst/after",  v_fetch(1'b0), 1'b0, 1'b0);

      @(negedge clk); #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
